stream_demux: RTL

- Registered 1-to-2 demultiplexer for valid/ready streams. It is the distribution counterpart of the generic 2-to-1 Mux: it steers one input stream to one of two destinations.
- Routing is decided per packet. `select` is sampled on the first beat of a packet and held until the beat flagged `in_last` is accepted.
- Each destination has a one-entry output register, so the block gives full throughput and isolates backpressure between the two destinations.
- Used wherever one datapath result must be delivered to one of two consumers.

---
 rtl/stream_demux.sv | 117 +++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer: each packet is steered whole to out0 or out1,
// and each destination has its own one-entry output register.
//
// state  | meaning
// -------+-------------------------------------------
// IDLE   | no packet in progress, select picks dest
// ROUTE0 | packet locked to out0 until last beat
// ROUTE1 | packet locked to out1 until last beat
module stream_demux #(
  parameter int unsigned width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [width-1:0] out0_data,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [width-1:0] out1_data,
  output logic             out1_last,
  input  logic             out1_ready
);

  typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_t;

  state_t           state_q, state_d;
  logic             out0_valid_q, out0_valid_d;
  logic [width-1:0] out0_data_q, out0_data_d;
  logic             out0_last_q, out0_last_d;
  logic             out1_valid_q, out1_valid_d;
  logic [width-1:0] out1_data_q, out1_data_d;
  logic             out1_last_q, out1_last_d;
  logic             dest;
  logic             accept;
  logic             load0, load1;

  always_comb begin
    dest = 1'b0;
    case (state_q)
      IDLE:    dest = select;
      ROUTE0:  dest = 1'b0;
      ROUTE1:  dest = 1'b1;
      default: dest = 1'b0;
    endcase
  end

  // in_ready looks through the destination register so a drain and a load can share a cycle
  assign in_ready = !reset && (dest ? (!out1_valid_q || out1_ready)
                                    : (!out0_valid_q || out0_ready));
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !dest;
  assign load1    = accept && dest;

  always_comb begin
    state_d      = state_q;
    out0_valid_d = out0_valid_q;
    out0_data_d  = out0_data_q;
    out0_last_d  = out0_last_q;
    out1_valid_d = out1_valid_q;
    out1_data_d  = out1_data_q;
    out1_last_d  = out1_last_q;

    if (accept) begin
      if (in_last) state_d = IDLE;
      else         state_d = dest ? ROUTE1 : ROUTE0;
    end

    if (load0) begin
      out0_valid_d = 1'b1;
      out0_data_d  = in_data;
      out0_last_d  = in_last;
    end else if (out0_valid_q && out0_ready) begin
      out0_valid_d = 1'b0;
    end

    if (load1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = in_data;
      out1_last_d  = in_last;
    end else if (out1_valid_q && out1_ready) begin
      out1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out0_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out0_last_q  <= 1'b0;
      out1_valid_q <= 1'b0;
      out1_data_q  <= '0;
      out1_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      out0_valid_q <= out0_valid_d;
      out0_data_q  <= out0_data_d;
      out0_last_q  <= out0_last_d;
      out1_valid_q <= out1_valid_d;
      out1_data_q  <= out1_data_d;
      out1_last_q  <= out1_last_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out0_data  = out0_data_q;
  assign out0_last  = out0_last_q;
  assign out1_valid = out1_valid_q;
  assign out1_data  = out1_data_q;
  assign out1_last  = out1_last_q;

endmodule
